// File: rtl/sub_nibble_serial.sv
// ============================================================================
// sub_nibble_serial : nibble-serial BW-bit subtractor D = A - B - Bin
//                     (4-bit CLA slice on A, ~B) with valid/ready handshakes
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sub_nibble_cla4 (
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   input  logic       i_c,
   output logic [3:0] o_s,
   output logic       o_c3,
   output logic       o_c4
);

   logic [3:0] w_g;
   logic [3:0] w_p;
   logic [4:0] w_c;

   assign w_g    = i_a & i_b;
   assign w_p    = i_a ^ i_b;
   assign w_c[0] = i_c;
   assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
   assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
   assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
   assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                 | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                 | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);

   assign o_s  = w_p ^ w_c[3:0];
   assign o_c3 = w_c[3];
   assign o_c4 = w_c[4];

endmodule

module sub_nibble_serial #(
   parameter int BW = 16
) (
   input  logic          i_clk,
   input  logic          i_rstn,
   input  logic          i_valid,
   output logic          o_ready,
   input  logic [BW-1:0] i_a,
   input  logic [BW-1:0] i_b,
   input  logic          i_bin,
   output logic          o_valid,
   input  logic          i_ready,
   output logic [BW-1:0] o_d,
   output logic          o_bout,
   output logic          o_zero,
   output logic          o_neg,
   output logic          o_ovf
);

   localparam int NIB = BW / 4;
   localparam int CW  = $clog2(NIB);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [BW-1:0]   a_q, a_d;
   logic [BW-1:0]   nb_q, nb_d;
   logic            carry_q, carry_d;
   logic [BW-1:0]   res_q, res_d;
   logic [BW-1:0]   dout_q, dout_d;
   logic            bout_q, bout_d;
   logic            zero_q, zero_d;
   logic            neg_q, neg_d;
   logic            ovf_q, ovf_d;

   logic [3:0]      w_a_nib;
   logic [3:0]      w_b_nib;
   logic [3:0]      w_sum;
   logic            w_c3;
   logic            w_c4;
   logic            w_last;

   assign w_a_nib = a_q[{cnt_q, 2'b00} +: 4];
   assign w_b_nib = nb_q[{cnt_q, 2'b00} +: 4];
   assign w_last  = (cnt_q == CW'(NIB - 1));

   sub_nibble_cla4 u_cla4 (
      .i_a  (w_a_nib),
      .i_b  (w_b_nib),
      .i_c  (carry_q),
      .o_s  (w_sum),
      .o_c3 (w_c3),
      .o_c4 (w_c4)
   );

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         nb_q    <= '0;
         carry_q <= 1'b0;
         res_q   <= '0;
         dout_q  <= '0;
         bout_q  <= 1'b0;
         zero_q  <= 1'b0;
         neg_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         nb_q    <= nb_d;
         carry_q <= carry_d;
         res_q   <= res_d;
         dout_q  <= dout_d;
         bout_q  <= bout_d;
         zero_q  <= zero_d;
         neg_q   <= neg_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      nb_d    = nb_q;
      carry_d = carry_q;
      res_d   = res_q;
      dout_d  = dout_q;
      bout_d  = bout_q;
      zero_d  = zero_q;
      neg_d   = neg_q;
      ovf_d   = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (i_valid) begin
               // Subtraction as A + ~B + ~Bin: invert once at capture.
               a_d     = i_a;
               nb_d    = ~i_b;
               carry_d = ~i_bin;
               cnt_d   = '0;
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            res_d[{cnt_q, 2'b00} +: 4] = w_sum;
            carry_d = w_c4;
            cnt_d   = cnt_q + CW'(1);
            if (w_last) begin
               // Publish the assembled result and flags together on DONE entry.
               dout_d  = res_d;
               bout_d  = ~w_c4;
               ovf_d   = w_c3 ^ w_c4;
               zero_d  = (res_d == '0);
               neg_d   = res_d[BW-1];
               cnt_d   = '0;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (i_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign o_ready = (state_q == S_IDLE);
   assign o_valid = (state_q == S_DONE);
   assign o_d     = dout_q;
   assign o_bout  = bout_q;
   assign o_zero  = zero_q;
   assign o_neg   = neg_q;
   assign o_ovf   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_sub_nibble_serial.sv
// ============================================================================
// tb_sub_nibble_serial : directed and random self-checking bench
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sub_nibble_serial;

   localparam int BW = 16;

   logic          i_clk;
   logic          i_rstn;
   logic          i_valid;
   logic          o_ready;
   logic [BW-1:0] i_a;
   logic [BW-1:0] i_b;
   logic          i_bin;
   logic          o_valid;
   logic          i_ready;
   logic [BW-1:0] o_d;
   logic          o_bout;
   logic          o_zero;
   logic          o_neg;
   logic          o_ovf;

   int n_tests = 0;
   int n_fail  = 0;

   sub_nibble_serial #(.BW(BW)) dut (
      .i_clk   (i_clk),
      .i_rstn  (i_rstn),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_a     (i_a),
      .i_b     (i_b),
      .i_bin   (i_bin),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_d     (o_d),
      .o_bout  (o_bout),
      .o_zero  (o_zero),
      .o_neg   (o_neg),
      .o_ovf   (o_ovf)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Runs one transaction from IDLE; lat counts edges from accept to o_valid.
   task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                        output logic [15:0] d, output logic [3:0] f, output int lat);
      i_a = a; i_b = b; i_bin = bin; i_valid = 1'b1;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      lat = 0;
      while (!o_valid && lat < 20) begin
         @(posedge i_clk); #1;
         lat++;
      end
      d = o_d;
      f = {o_bout, o_zero, o_neg, o_ovf};
      i_ready = 1'b1;
      @(posedge i_clk); #1;
      i_ready = 1'b0;
   endtask

   task automatic test_reset();
      i_rstn = 1'b0; i_valid = 1'b1; i_ready = 1'b0;
      i_a = 16'hABCD; i_b = 16'h1234; i_bin = 1'b1;
      repeat (3) @(posedge i_clk);
      #1;
      n_tests++;
      if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_d !== 16'h0000 ||
          {o_bout, o_zero, o_neg, o_ovf} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset: ready=%b valid=%b d=%h flags=%b, want ready=1 valid=0 d=0000 flags=0000",
                  o_ready, o_valid, o_d, {o_bout, o_zero, o_neg, o_ovf});
      end
      i_valid = 1'b0;
      i_rstn  = 1'b1;
      @(posedge i_clk); #1;
   endtask

   task automatic test_vectors();
      // {a, b, bin, d, bout, zero, neg, ovf}
      logic [15:0] va [9] = '{16'h1234, 16'h0000, 16'h8000, 16'h7FFF, 16'h5555,
                              16'h0000, 16'hFFFF, 16'h0F0F, 16'h8000};
      logic [15:0] vb [9] = '{16'h0034, 16'h0001, 16'h0001, 16'hFFFF, 16'h5554,
                              16'h0000, 16'hFFFF, 16'h00F0, 16'h7FFF};
      logic        vc [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [15:0] vd [9] = '{16'h1200, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000,
                              16'hFFFF, 16'h0000, 16'h0E1F, 16'h0000};
      logic [3:0]  vf [9] = '{4'b0000, 4'b1010, 4'b0001, 4'b1011, 4'b0100,
                              4'b1010, 4'b0100, 4'b0000, 4'b0101};
      logic [15:0] d;
      logic [3:0]  f;
      int          lat;
      for (int i = 0; i < 9; i++) begin
         do_op(va[i], vb[i], vc[i], d, f, lat);
         n_tests++;
         if (d !== vd[i] || f !== vf[i] || lat !== 4) begin
            n_fail++;
            $display("FAIL vector %0d (%h-%h-%b): d=%h flags=%b lat=%0d, want d=%h flags=%b lat=4",
                     i, va[i], vb[i], vc[i], d, f, lat, vd[i], vf[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      int          wait_cyc;
      logic [15:0] d;
      logic [3:0]  f;
      int          lat;
      i_a = 16'h1234; i_b = 16'h0034; i_bin = 1'b0; i_valid = 1'b1;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      wait_cyc = 0;
      while (!o_valid && wait_cyc < 20) begin
         @(posedge i_clk); #1;
         wait_cyc++;
      end
      for (int k = 0; k < 3; k++) begin
         i_valid = 1'b1; i_a = 16'hFFFF; i_b = 16'h0F0F; i_bin = k[0];
         @(posedge i_clk); #1;
         n_tests++;
         if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_d !== 16'h1200 ||
             {o_bout, o_zero, o_neg, o_ovf} !== 4'b0000) begin
            n_fail++;
            $display("FAIL stall cycle %0d: valid=%b ready=%b d=%h flags=%b, want valid=1 ready=0 d=1200 flags=0000",
                     k, o_valid, o_ready, o_d, {o_bout, o_zero, o_neg, o_ovf});
         end
      end
      i_valid = 1'b0; i_ready = 1'b1;
      @(posedge i_clk); #1;
      i_ready = 1'b0;
      n_tests++;
      if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_d !== 16'h1200) begin
         n_fail++;
         $display("FAIL release: valid=%b ready=%b d=%h, want valid=0 ready=1 d=1200",
                  o_valid, o_ready, o_d);
      end
      do_op(16'h0100, 16'h0001, 1'b0, d, f, lat);
      n_tests++;
      if (d !== 16'h00FF || f !== 4'b0000 || lat !== 4) begin
         n_fail++;
         $display("FAIL after stall: d=%h flags=%b lat=%0d, want d=00FF flags=0000 lat=4", d, f, lat);
      end
   endtask

   task automatic test_back_to_back();
      int first  = -1;
      int second = -1;
      i_a = 16'h3000; i_b = 16'h1000; i_bin = 1'b0;
      i_valid = 1'b1; i_ready = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(posedge i_clk); #1;
         if (k == 1) begin
            n_tests++;
            if (o_d !== 16'h00FF) begin
               n_fail++;
               $display("FAIL hold in calc: d=%h, want 00FF", o_d);
            end
         end
         if (o_valid) begin
            if (first < 0) first = k;
            else if (second < 0) second = k;
         end
      end
      i_valid = 1'b0;
      repeat (8) @(posedge i_clk);
      #1;
      i_ready = 1'b0;
      n_tests++;
      if (first !== 4 || second !== 10 || o_d !== 16'h2000 || o_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL back-to-back: valid at %0d,%0d d=%h ready=%b, want 4,10 d=2000 ready=1",
                  first, second, o_d, o_ready);
      end
   endtask

   task automatic test_reset_mid_calc();
      logic [15:0] d;
      logic [3:0]  f;
      int          lat;
      i_a = 16'h1234; i_b = 16'h0034; i_bin = 1'b0; i_valid = 1'b1;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      @(posedge i_clk); #2;
      i_rstn = 1'b0;
      #1;
      n_tests++;
      if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_d !== 16'h0000 ||
          {o_bout, o_zero, o_neg, o_ovf} !== 4'b0000) begin
         n_fail++;
         $display("FAIL async reset: ready=%b valid=%b d=%h flags=%b, want ready=1 valid=0 d=0000 flags=0000",
                  o_ready, o_valid, o_d, {o_bout, o_zero, o_neg, o_ovf});
      end
      @(posedge i_clk); #1;
      i_rstn = 1'b1;
      @(posedge i_clk); #1;
      do_op(16'hA5A5, 16'h5A5A, 1'b0, d, f, lat);
      n_tests++;
      if (d !== 16'h4B4B || f !== 4'b0001 || lat !== 4) begin
         n_fail++;
         $display("FAIL after reset: d=%h flags=%b lat=%0d, want d=4B4B flags=0001 lat=4", d, f, lat);
      end
   endtask

   task automatic test_random();
      logic [15:0] a, b, d, ed;
      logic        bin;
      logic [16:0] full;
      logic [3:0]  f, ef;
      int          lat;
      for (int i = 0; i < 300; i++) begin
         a   = 16'($urandom);
         b   = 16'($urandom);
         bin = 1'($urandom);
         if (i % 10 == 0) b = a;
         full = {1'b0, a} - {1'b0, b} - {16'h0000, bin};
         ed   = full[15:0];
         ef   = {full[16], (ed == 16'h0000), ed[15], (a[15] != b[15]) && (ed[15] != a[15])};
         do_op(a, b, bin, d, f, lat);
         n_tests++;
         if (d !== ed || f !== ef || lat !== 4) begin
            n_fail++;
            $display("FAIL random %0d (%h-%h-%b): d=%h flags=%b lat=%0d, want d=%h flags=%b lat=4",
                     i, a, b, bin, d, f, lat, ed, ef);
         end
      end
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_calc();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
